// File: rtl/mem_arbiter.sv
// Arbitrates the single memory bus between instruction fetch and the data path.
// Data wins by default; a starvation counter forces a fetch grant after STARVE_LIMIT data wins.
module mem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ready,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_cmd,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wmask,
   output logic        d_ready,
   output logic [31:0] d_rdata,
   output logic        mem_valid,
   output logic        mem_cmd,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t      r_state, w_state_next;
   logic [3:0]  r_starve_cnt, w_starve_cnt_next;
   logic        r_owner, w_owner_next;          // 1 = data path owns the bus
   logic        r_mem_valid, w_mem_valid_next;
   logic        r_mem_cmd, w_mem_cmd_next;
   logic [31:0] r_mem_addr, w_mem_addr_next;
   logic [31:0] r_mem_wdata, w_mem_wdata_next;
   logic [3:0]  r_mem_wmask, w_mem_wmask_next;
   logic        r_i_ready, w_i_ready_next;
   logic        r_d_ready, w_d_ready_next;
   logic [31:0] r_i_rdata, w_i_rdata_next;
   logic [31:0] r_d_rdata, w_d_rdata_next;
   logic        w_fetch_win;
   logic        w_unused;

   // Byte offsets are dropped: the bus is word addressed.
   assign w_unused = ^{i_addr[1:0], d_addr[1:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_starve_cnt <= 4'd0;
         r_owner      <= 1'b0;
         r_mem_valid  <= 1'b0;
         r_mem_cmd    <= 1'b0;
         r_mem_addr   <= 32'd0;
         r_mem_wdata  <= 32'd0;
         r_mem_wmask  <= 4'd0;
         r_i_ready    <= 1'b0;
         r_d_ready    <= 1'b0;
         r_i_rdata    <= 32'd0;
         r_d_rdata    <= 32'd0;
      end else begin
         r_state      <= w_state_next;
         r_starve_cnt <= w_starve_cnt_next;
         r_owner      <= w_owner_next;
         r_mem_valid  <= w_mem_valid_next;
         r_mem_cmd    <= w_mem_cmd_next;
         r_mem_addr   <= w_mem_addr_next;
         r_mem_wdata  <= w_mem_wdata_next;
         r_mem_wmask  <= w_mem_wmask_next;
         r_i_ready    <= w_i_ready_next;
         r_d_ready    <= w_d_ready_next;
         r_i_rdata    <= w_i_rdata_next;
         r_d_rdata    <= w_d_rdata_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_starve_cnt_next = r_starve_cnt;
      w_owner_next      = r_owner;
      w_mem_valid_next  = r_mem_valid;
      w_mem_cmd_next    = r_mem_cmd;
      w_mem_addr_next   = r_mem_addr;
      w_mem_wdata_next  = r_mem_wdata;
      w_mem_wmask_next  = r_mem_wmask;
      w_i_ready_next    = 1'b0;
      w_d_ready_next    = 1'b0;
      w_i_rdata_next    = r_i_rdata;
      w_d_rdata_next    = r_d_rdata;
      w_fetch_win       = i_req && (!d_req || r_starve_cnt == LIMIT);

      case (r_state)
         IDLE: begin
            if (i_req || d_req) begin
               w_state_next     = BUSY;
               w_mem_valid_next = 1'b1;
               if (w_fetch_win) begin
                  w_owner_next      = 1'b0;
                  w_mem_cmd_next    = 1'b0;
                  w_mem_addr_next   = {i_addr[31:2], 2'b00};
                  w_mem_wdata_next  = 32'd0;
                  w_mem_wmask_next  = 4'd0;
                  w_starve_cnt_next = 4'd0;
               end else begin
                  w_owner_next     = 1'b1;
                  w_mem_cmd_next   = d_cmd;
                  w_mem_addr_next  = {d_addr[31:2], 2'b00};
                  w_mem_wdata_next = d_wdata;
                  w_mem_wmask_next = d_cmd ? d_wmask : 4'd0;
                  if (!i_req)
                     w_starve_cnt_next = 4'd0;
                  else if (r_starve_cnt != LIMIT)
                     w_starve_cnt_next = r_starve_cnt + 4'd1;
               end
            end
         end
         BUSY: begin
            if (mem_ready) begin
               w_mem_valid_next = 1'b0;
               w_state_next     = RESP;
               if (r_owner) begin
                  w_d_ready_next = 1'b1;
                  w_d_rdata_next = r_mem_cmd ? 32'd0 : mem_rdata;
               end else begin
                  w_i_ready_next = 1'b1;
                  w_i_rdata_next = mem_rdata;
               end
            end
         end
         RESP:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   assign mem_valid = r_mem_valid;
   assign mem_cmd   = r_mem_cmd;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_wmask = r_mem_wmask;
   assign i_ready   = r_i_ready;
   assign d_ready   = r_d_ready;
   assign i_rdata   = r_i_rdata;
   assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;
   localparam int STARVE_LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = 32'd0;
   logic        i_ready;
   logic [31:0] i_rdata;
   logic        d_req = 1'b0;
   logic        d_cmd = 1'b0;
   logic [31:0] d_addr = 32'd0;
   logic [31:0] d_wdata = 32'd0;
   logic [3:0]  d_wmask = 4'd0;
   logic        d_ready;
   logic [31:0] d_rdata;
   logic        mem_valid;
   logic        mem_cmd;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = 32'd0;

   always #5 clk = ~clk;

   mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
      .d_req(d_req), .d_cmd(d_cmd), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
      .d_ready(d_ready), .d_rdata(d_rdata),
      .mem_valid(mem_valid), .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   int n_checks = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Transaction-level model: one open bus transaction at most, a one-cycle completion
   // notice, and a grant decision only when the bus is free and no notice is showing.
   bit          m_started = 0;
   bit          m_open = 0;
   bit          m_notice = 0;
   bit          m_to_data = 0;
   int          m_data_streak = 0;
   logic        m_cmd = 1'b0;
   logic [31:0] m_addr = 32'd0;
   logic [31:0] m_wdata = 32'd0;
   logic [3:0]  m_wmask = 4'd0;
   logic [31:0] m_i_word = 32'd0;
   logic [31:0] m_d_word = 32'd0;

   always @(posedge clk) begin
      if (reset) begin
         m_started     <= 1;
         m_open        <= 0;
         m_notice      <= 0;
         m_to_data     <= 0;
         m_data_streak <= 0;
         m_cmd         <= 1'b0;
         m_addr        <= 32'd0;
         m_wdata       <= 32'd0;
         m_wmask       <= 4'd0;
         m_i_word      <= 32'd0;
         m_d_word      <= 32'd0;
      end else if (m_notice) begin
         m_notice <= 0;
      end else if (m_open) begin
         if (mem_ready) begin
            m_open   <= 0;
            m_notice <= 1;
            if (m_to_data) m_d_word <= m_cmd ? 32'd0 : mem_rdata;
            else           m_i_word <= mem_rdata;
         end
      end else if (i_req || d_req) begin
         m_open <= 1;
         if (i_req && (!d_req || m_data_streak >= STARVE_LIMIT)) begin
            m_to_data     <= 0;
            m_cmd         <= 1'b0;
            m_addr        <= i_addr & 32'hFFFF_FFFC;
            m_wdata       <= 32'd0;
            m_wmask       <= 4'd0;
            m_data_streak <= 0;
         end else begin
            m_to_data     <= 1;
            m_cmd         <= d_cmd;
            m_addr        <= d_addr & 32'hFFFF_FFFC;
            m_wdata       <= d_wdata;
            m_wmask       <= d_cmd ? d_wmask : 4'd0;
            m_data_streak <= i_req ? ((m_data_streak + 1 > STARVE_LIMIT) ? STARVE_LIMIT
                                                                         : m_data_streak + 1) : 0;
         end
      end
   end

   always @(negedge clk) begin
      if (m_started) begin
         chk("mem_valid", 32'(mem_valid), 32'(m_open));
         if (m_open) begin
            chk("mem_cmd", 32'(mem_cmd), 32'(m_cmd));
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("mem_wmask", 32'(mem_wmask), 32'(m_wmask));
         end
         chk("i_ready", 32'(i_ready), 32'(m_notice && !m_to_data));
         chk("d_ready", 32'(d_ready), 32'(m_notice && m_to_data));
         chk("i_rdata", i_rdata, m_i_word);
         chk("d_rdata", d_rdata, m_d_word);
      end
   end

   logic [5:0] order;

   initial begin
      step();
      step();
      chk("rst_mem_valid", 32'(mem_valid), 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_i_ready", 32'(i_ready), 0);
      chk("rst_d_ready", 32'(d_ready), 0);
      chk("rst_d_rdata", d_rdata, 0);
      reset = 1'b0;

      // fetch only, zero wait
      i_req = 1'b1; i_addr = 32'h0000_0106; mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      step();
      chk("f_valid", 32'(mem_valid), 1);
      chk("f_addr", mem_addr, 32'h0000_0104);
      chk("f_cmd", 32'(mem_cmd), 0);
      chk("f_wmask", 32'(mem_wmask), 0);
      step();
      chk("f_iready", 32'(i_ready), 1);
      chk("f_irdata", i_rdata, 32'hDEAD_BEEF);
      chk("f_dready", 32'(d_ready), 0);
      i_req = 1'b0; mem_ready = 1'b0;
      step();
      chk("f_pulse_end", 32'(i_ready), 0);

      // store with three wait cycles
      d_req = 1'b1; d_cmd = 1'b1; d_addr = 32'h100; d_wdata = 32'h0000_AB00; d_wmask = 4'b0010;
      step();
      for (int k = 0; k < 4; k++) begin
         chk("s_valid", 32'(mem_valid), 1);
         chk("s_cmd", 32'(mem_cmd), 1);
         chk("s_addr", mem_addr, 32'h100);
         chk("s_wdata", mem_wdata, 32'h0000_AB00);
         chk("s_wmask", 32'(mem_wmask), 32'h2);
         chk("s_no_ready", 32'(d_ready), 0);
         mem_ready = (k == 3);
         step();
      end
      chk("s_dready", 32'(d_ready), 1);
      chk("s_drdata", d_rdata, 0);
      chk("s_valid_off", 32'(mem_valid), 0);
      d_req = 1'b0; mem_ready = 1'b0;
      step();
      chk("s_pulse_end", 32'(d_ready), 0);

      // collision: data load (full mask) first, then fetch
      i_req = 1'b1; i_addr = 32'h200;
      d_req = 1'b1; d_cmd = 1'b0; d_addr = 32'h303; d_wmask = 4'hF; d_wdata = 32'h55;
      mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
      step();
      chk("c_addr", mem_addr, 32'h300);
      chk("c_cmd", 32'(mem_cmd), 0);
      chk("c_wmask", 32'(mem_wmask), 0);
      step();
      chk("c_dready", 32'(d_ready), 1);
      chk("c_drdata", d_rdata, 32'h1234_5678);
      chk("c_iready", 32'(i_ready), 0);
      d_req = 1'b0; mem_rdata = 32'hCAFE_F00D;
      step();
      chk("c_idle", 32'(mem_valid), 0);
      step();
      chk("c_faddr", mem_addr, 32'h200);
      step();
      chk("c_f_iready", 32'(i_ready), 1);
      chk("c_f_irdata", i_rdata, 32'hCAFE_F00D);
      i_req = 1'b0;
      step();

      // starvation: both requesters keep asking
      i_req = 1'b1; i_addr = 32'h500; d_req = 1'b1; d_cmd = 1'b0; d_addr = 32'h400; mem_ready = 1'b1;
      order = 6'd0;
      for (int g = 0; g < 6; g++) begin
         step();
         order[g] = (mem_addr == 32'h500);
         step();
         step();
      end
      chk("starve_order", 32'(order), 32'h10);
      i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
      step();

      // reset while busy abandons the transaction
      d_req = 1'b1; d_cmd = 1'b1; d_addr = 32'h600; d_wdata = 32'h77; d_wmask = 4'hF;
      step();
      chk("r_valid", 32'(mem_valid), 1);
      reset = 1'b1; d_req = 1'b0;
      step();
      chk("r_valid_off", 32'(mem_valid), 0);
      chk("r_dready", 32'(d_ready), 0);
      reset = 1'b0; mem_ready = 1'b1;
      step();
      chk("r_dready2", 32'(d_ready), 0);
      chk("r_valid2", 32'(mem_valid), 0);
      step();
      chk("r_dready3", 32'(d_ready), 0);
      mem_ready = 1'b0;

      // random traffic
      for (int c = 0; c < 4000; c++) begin
         step();
         reset     = ($urandom_range(0, 149) == 0);
         mem_ready = ($urandom_range(0, 2) == 0);
         mem_rdata = $urandom;
         if (i_ready || !i_req) begin
            i_req  = ($urandom_range(0, 2) != 0);
            i_addr = $urandom;
         end else if ($urandom_range(0, 7) == 0) begin
            i_addr = $urandom;
         end
         if (d_ready || !d_req) begin
            d_req   = ($urandom_range(0, 2) != 0);
            d_cmd   = 1'($urandom_range(0, 1));
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_wmask = 4'($urandom_range(0, 15));
         end else if ($urandom_range(0, 7) == 0) begin
            d_wdata = $urandom;
         end
      end
      reset = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory bus between the instruction-fetch port and the load/store data path (the data-memory formatting unit).
- Accepts one request per requester using a req/ready handshake.
- Sequences one bus transaction at a time and returns read data to the winning requester.
- Data requests have priority. A starvation counter guarantees fetch progress.

Parameters:
- STARVE_LIMIT, 4, maximum consecutive data grants while i_req is pending before fetch is forced to win (range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- i_req  input  1  fetch request; held high until i_ready.
- i_addr  input  32  fetch byte address.
- i_ready  output  1  one-cycle completion pulse to fetch.
- i_rdata  output  32  fetch read data; valid while i_ready=1.
- d_req  input  1  data request; held high until d_ready.
- d_cmd  input  1  0=load, 1=store.
- d_addr  input  32  word-aligned data address.
- d_wdata  input  32  store data, pre-shifted.
- d_wmask  input  4  byte-enable mask for stores.
- d_ready  output  1  one-cycle completion pulse to data path.
- d_rdata  output  32  raw load word; valid while d_ready=1.
- mem_valid  output  1  bus request active.
- mem_cmd  output  1  0=read, 1=write.
- mem_addr  output  32  bus word address.
- mem_wdata  output  32  bus write data.
- mem_wmask  output  4  bus byte enables.
- mem_ready  input  1  memory accepts/completes the transaction this cycle.
- mem_rdata  input  32  memory read data; valid when mem_ready=1 and mem_cmd=0.

Behaviour:
- Clocking and reset: all state changes on the rising edge of clk.
- Reset values when reset=1 at an edge:
  - state=IDLE, starve_cnt=0, owner=0.
  - mem_valid=0, mem_cmd=0, mem_addr=0, mem_wdata=0, mem_wmask=0.
  - i_ready=0, d_ready=0, i_rdata=0, d_rdata=0.
- Reset mid-transaction abandons the transaction; no ready pulse is ever issued for it.
- FSM states are IDLE, BUSY and RESP.
- IDLE:
  - No request: stay in IDLE.
  - Else pick a winner:
    - fetch wins if i_req && (!d_req || starve_cnt==STARVE_LIMIT);
    - otherwise data wins.
  - Latch the winner's request into the bus registers and go to BUSY.
- Latched bus values by winner:
  - Fetch: mem_cmd=0, mem_addr={i_addr[31:2],2'b00}, mem_wdata=0, mem_wmask=0.
  - Data: mem_cmd=d_cmd, mem_addr={d_addr[31:2],2'b00}, mem_wdata=d_wdata.
    - mem_wmask=d_wmask if d_cmd=1, else 4'b0000.
- Starvation counter:
  - On a data grant with i_req=1: starve_cnt increments, saturating at STARVE_LIMIT.
  - On a data grant with i_req=0: starve_cnt=0.
  - On a fetch grant: starve_cnt=0.
- BUSY:
  - mem_valid=1, and all mem_* outputs are held stable.
  - Stay in BUSY while mem_ready=0; there is no timeout.
  - On mem_ready=1:
    - capture mem_rdata into the owner's rdata register (stores capture 0);
    - set mem_valid=0;
    - go to RESP.
- RESP:
  - The owner's ready output is 1 for exactly this cycle; the other ready output is 0.
  - rdata holds its value until the next completion for that port.
  - Next state is IDLE.
  - Requesters may drop req, or keep it high to issue a new request; it is sampled in IDLE.
- Latency: request sampled in IDLE at edge N gives mem_valid high from cycle N+1. mem_ready at cycle M gives ready high in cycle M+1. Minimum is 3 cycles per transaction.
- Request changes: changes to the inputs of the granted requester during BUSY/RESP are ignored. A non-granted request waits.
- Simultaneous requests: i_req and d_req both rising in the same IDLE cycle means data wins, unless the starvation rule applies.
- mem_ready while not in BUSY is ignored.
- The arbiter never issues two overlapping bus transactions.

Test Plan:
- Fetch only, zero-wait: i_req=1, i_addr=0x0000_0106, mem_ready=1 on the first valid cycle, mem_rdata=0xDEAD_BEEF. Required: mem_addr=0x0000_0104, mem_cmd=0, mem_wmask=0. i_ready pulses 1 cycle with i_rdata=0xDEAD_BEEF, 3 cycles after req sampled.
- Store with waits: d_req=1, d_cmd=1, d_addr=0x100, d_wdata=0x0000_AB00, d_wmask=4'b0010, mem_ready low for 3 cycles. Required: mem_valid held 4 cycles with stable outputs, then a single d_ready pulse and d_rdata=0.
- Collision: i_req and d_req asserted together with starve_cnt=0. Required: data transaction first. Fetch is served immediately after, on the next IDLE.
- Starvation: d_req held high continuously (new request each RESP), i_req held high, STARVE_LIMIT=4. Required: 4 data grants, then a fetch grant, and starve_cnt returns to 0.
- Load with d_wmask=4'b1111 and d_cmd=0. Required: mem_wmask=0 on the bus, and d_rdata equals mem_rdata.
- Reset asserted in BUSY with mem_ready=0. Required: next cycle mem_valid=0, no ready pulse, state IDLE. A subsequent mem_ready=1 is ignored.
